data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Arbitrates the single-port data memory between two requesters: the pipeline MEM stage and an external requester (debug loader / IO DMA).
- The pipeline has default ownership with zero added latency.
- The external requester uses a req/ack handshake and gets one-cycle accesses.
- A starvation counter forces an external grant by stalling the pipeline.
- The block sits between the EX/MEM pipe register outputs and the data memory.

Parameters:
MAX_WAIT, 4, cycles an external request may wait behind a busy pipeline before a forced grant
WAIT_WIDTH, 4, width of the wait counter; must hold MAX_WAIT
CNT_WIDTH, 16, width of the grant counters (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
PipeMemRead_M  in  1  pipeline load in MEM stage
PipeMemWrite_M  in  1  pipeline store in MEM stage
PipeAddress_M  in  32  pipeline address
PipeWriteData_M  in  32  pipeline store data
PipeReadData  out  32  load data to MEM/WB, combinational copy of MemReadData
StallPipe  out  1  freeze IF..MEM stages for this cycle
ExtReq  in  1  external request, held until ExtAck
ExtWrite  in  1  1=write, 0=read
ExtAddress  in  32  external address
ExtWriteData  in  32  external write data
ExtAck  out  1  one-cycle completion pulse, registered
ExtReadData  out  32  registered read data, valid with ExtAck and held after
MemAddress  out  32  to data memory
MemWriteData  out  32  to data memory
MemWrite  out  1  to data memory
MemRead  out  1  to data memory
MemReadData  in  32  from data memory, combinational read

Behaviour:
- Definition: pipe_busy = PipeMemRead_M | PipeMemWrite_M.
- Reset (reset=0, async):
  - state=IDLE, wait_cnt=0, ExtAck=0, ExtReadData=0, latched ext regs=0.
  - Memory ports immediately follow pipe inputs.
- FSM states: IDLE, EXT_ACCESS, EXT_ACK.
- IDLE:
  - Memory ports driven by pipe inputs; StallPipe=0.
  - If ExtReq && (!pipe_busy || wait_cnt==MAX_WAIT):
    - latch ExtWrite/ExtAddress/ExtWriteData;
    - wait_cnt<=0;
    - go to EXT_ACCESS.
  - Else if ExtReq: wait_cnt increments, saturating at MAX_WAIT.
  - Else: wait_cnt<=0.
- EXT_ACCESS (exactly 1 cycle):
  - Memory ports driven from latched ext regs.
  - MemWrite=latched write; MemRead=~latched write.
  - StallPipe=pipe_busy; a pipe access never reaches memory in this cycle.
  - On a read, ExtReadData<=MemReadData at the clock edge; on a write, ExtReadData is unchanged.
  - Next state: EXT_ACK.
- EXT_ACK:
  - ExtAck=1; pipe owns memory again; StallPipe=0.
  - ExtReq is ignored this cycle.
  - Next state: IDLE.
  - If ExtReq is still high in the following IDLE cycle, it is a new request.
- Latency:
  - Idle pipe: grant edge +1 cycle = EXT_ACCESS; ExtAck in the cycle after that, i.e. 2 cycles after the ExtReq sample.
  - Busy pipe: at most MAX_WAIT extra cycles.
- MAX_WAIT=0: external request is granted on first sample, regardless of pipe.
- Simultaneous pipe access and non-forced ExtReq in IDLE: pipe wins.
- Reset asserted during EXT_ACCESS:
  - No memory write is issued unless a clock edge occurred before reset.
  - ExtAck is never generated for the aborted request.
- PipeReadData = MemReadData at all times; it is only meaningful when the pipe owns memory.

Optional Feature:
Macro DATA_MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs PipeGrantCount and ExtGrantCount [CNT_WIDTH-1:0], both reset to 0.
  - PipeGrantCount increments on each cycle where pipe_busy && !StallPipe.
  - ExtGrantCount increments on each EXT_ACCESS cycle.
  - Both counters wrap at 2^CNT_WIDTH.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset low mid-run with state EXT_ACK -> ExtAck=0, ExtReadData=0, MemAddress=PipeAddress_M immediately, without waiting for a clock.
- Pipe idle; ExtReq read at 0x10010004 (memory holds 0xDEADBEEF) in cycle 0 -> EXT_ACCESS in cycle 1 with MemRead=1, MemAddress=0x10010004; ExtAck=1 and ExtReadData=0xDEADBEEF in cycle 2; StallPipe=0 throughout.
- MAX_WAIT=3, pipe load every cycle, ExtReq write 0x0000CAFE to 0x10010010 at cycle 0 -> grant at cycle 3, EXT_ACCESS at cycle 4 with StallPipe=1 and MemWrite=1, ExtAck at cycle 5; memory reads back 0x0000CAFE.
- Pipe store and ExtReq both in cycle 0, pipe idle in cycle 1 -> cycle 0 memory sees the pipe store; grant at cycle 1, EXT_ACCESS at cycle 2, ExtAck at cycle 3.
- ExtReq held high through ExtAck -> a second EXT_ACCESS starts 2 cycles after the first ExtAck (IDLE sample, then grant), never back-to-back.
- With DATA_MEM_ARB_STATS_EN defined: 5 unstalled pipe accesses and 2 external accesses -> PipeGrantCount=5, ExtGrantCount=2.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: the pipeline MEM stage owns the port by default,
// an external req/ack requester gets one-cycle accesses, forced after MAX_WAIT busy cycles.
// Optional grant counters are enabled by defining DATA_MEM_ARB_STATS_EN.
module data_mem_arbiter #(
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned WAIT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PipeMemRead_M,
  input  logic        PipeMemWrite_M,
  input  logic [31:0] PipeAddress_M,
  input  logic [31:0] PipeWriteData_M,
  output logic [31:0] PipeReadData,
  output logic        StallPipe,
  input  logic        ExtReq,
  input  logic        ExtWrite,
  input  logic [31:0] ExtAddress,
  input  logic [31:0] ExtWriteData,
  output logic        ExtAck,
  output logic [31:0] ExtReadData,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
`ifdef DATA_MEM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] PipeGrantCount,
  output logic [CNT_WIDTH-1:0] ExtGrantCount
`endif
);

  localparam logic [WAIT_WIDTH-1:0] WaitMax = WAIT_WIDTH'(MAX_WAIT);

  // Parameter sanity checks at elaboration.
  if (WAIT_WIDTH < 32 && MAX_WAIT >= (32'd1 << WAIT_WIDTH)) begin : gWaitWidthCheck
    $error("WAIT_WIDTH too narrow to hold MAX_WAIT");
  end
  if (CNT_WIDTH == 0) begin : gCntWidthCheck
    $error("CNT_WIDTH must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXT_ACCESS = 2'd1,
    EXT_ACK    = 2'd2
  } arbStateT;

  arbStateT              state;
  arbStateT              stateNext;
  logic [WAIT_WIDTH-1:0] waitCnt;
  logic [WAIT_WIDTH-1:0] waitCntNext;
  logic                  latchExt;
  logic                  extWriteQ;
  logic [31:0]           extAddressQ;
  logic [31:0]           extWriteDataQ;
  logic                  pipeBusy;

  assign pipeBusy     = PipeMemRead_M | PipeMemWrite_M;
  assign PipeReadData = MemReadData;

  // Next-state, wait counter and memory port steering.
  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    latchExt     = 1'b0;
    StallPipe    = 1'b0;
    MemAddress   = PipeAddress_M;
    MemWriteData = PipeWriteData_M;
    MemWrite     = PipeMemWrite_M;
    MemRead      = PipeMemRead_M;
    case (state)
      IDLE: begin
        if (ExtReq && (!pipeBusy || waitCnt == WaitMax)) begin
          latchExt    = 1'b1;
          waitCntNext = '0;
          stateNext   = EXT_ACCESS;
        end else if (ExtReq) begin
          if (waitCnt != WaitMax) waitCntNext = waitCnt + WAIT_WIDTH'(1);
        end else begin
          waitCntNext = '0;
        end
      end
      EXT_ACCESS: begin
        // The pipe access is suppressed entirely while the external one runs.
        MemAddress   = extAddressQ;
        MemWriteData = extWriteDataQ;
        MemWrite     = extWriteQ;
        MemRead      = ~extWriteQ;
        StallPipe    = pipeBusy;
        stateNext    = EXT_ACK;
      end
      EXT_ACK: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, latched external request and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      waitCnt       <= '0;
      extWriteQ     <= 1'b0;
      extAddressQ   <= '0;
      extWriteDataQ <= '0;
      ExtAck        <= 1'b0;
      ExtReadData   <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (latchExt) begin
        extWriteQ     <= ExtWrite;
        extAddressQ   <= ExtAddress;
        extWriteDataQ <= ExtWriteData;
      end
      ExtAck <= (state == EXT_ACCESS);
      if (state == EXT_ACCESS && !extWriteQ) ExtReadData <= MemReadData;
    end
  end

`ifdef DATA_MEM_ARB_STATS_EN
  // Grant statistics; both counters wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PipeGrantCount <= '0;
      ExtGrantCount  <= '0;
    end else begin
      if (pipeBusy && !StallPipe) PipeGrantCount <= PipeGrantCount + CNT_WIDTH'(1);
      if (state == EXT_ACCESS) ExtGrantCount <= ExtGrantCount + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory and a
// scoreboard of expected external completions.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        PipeMemRead_M;
  logic        PipeMemWrite_M;
  logic [31:0] PipeAddress_M;
  logic [31:0] PipeWriteData_M;
  logic [31:0] PipeReadData;
  logic        StallPipe;
  logic        ExtReq;
  logic        ExtWrite;
  logic [31:0] ExtAddress;
  logic [31:0] ExtWriteData;
  logic        ExtAck;
  logic [31:0] ExtReadData;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;
`ifdef DATA_MEM_ARB_STATS_EN
  logic [15:0] PipeGrantCount;
  logic [15:0] ExtGrantCount;
`endif

  data_mem_arbiter #(
    .MAX_WAIT  (3),
    .WAIT_WIDTH(4),
    .CNT_WIDTH (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PipeMemRead_M  (PipeMemRead_M),
    .PipeMemWrite_M (PipeMemWrite_M),
    .PipeAddress_M  (PipeAddress_M),
    .PipeWriteData_M(PipeWriteData_M),
    .PipeReadData   (PipeReadData),
    .StallPipe      (StallPipe),
    .ExtReq         (ExtReq),
    .ExtWrite       (ExtWrite),
    .ExtAddress     (ExtAddress),
    .ExtWriteData   (ExtWriteData),
    .ExtAck         (ExtAck),
    .ExtReadData    (ExtReadData),
    .MemAddress     (MemAddress),
    .MemWriteData   (MemWriteData),
    .MemWrite       (MemWrite),
    .MemRead        (MemRead),
    .MemReadData    (MemReadData)
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    .PipeGrantCount (PipeGrantCount),
    .ExtGrantCount  (ExtGrantCount)
`endif
  );

  // Word-addressed data memory, combinational read, write on the clock edge.
  logic [31:0] mem [64];
  assign MemReadData = mem[MemAddress[7:2]];
  always @(posedge clk) if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        isWrite;
    logic [31:0] rdata;
  } extExpT;

  extExpT      sbQ[$];
  logic [31:0] expReadData;
  int          checks = 0;
  int          errors = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected completion and checks the returned read data.
  task automatic checkAck(input string tag);
    extExpT t;
    checks++;
    assert (sbQ.size() != 0) else begin
      errors++;
      $error("FAIL %s/sb observed=ack expected=no_pending_request", tag);
    end
    if (sbQ.size() != 0) begin
      t = sbQ.pop_front();
      if (!t.isWrite) expReadData = t.rdata;
      chk32({tag, "/rdata"}, ExtReadData, expReadData);
    end
  endtask

  task automatic setPipe(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    PipeMemRead_M   = rd;
    PipeMemWrite_M  = wr;
    PipeAddress_M   = addr;
    PipeWriteData_M = data;
  endtask

  task automatic setExt(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    ExtReq       = req;
    ExtWrite     = wr;
    ExtAddress   = addr;
    ExtWriteData = data;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    setPipe(1'b0, 1'b0, 32'h0, 32'h0);
    setExt(1'b0, 1'b0, 32'h0, 32'h0);
    expReadData = 32'h0;

    // Reset state and memory ports following the pipe during reset.
    #1;
    chk1("rst/extAck", ExtAck, 1'b0);
    chk32("rst/extReadData", ExtReadData, 32'h0);
    chk1("rst/stall", StallPipe, 1'b0);
    setPipe(1'b1, 1'b0, 32'h1001_0040, 32'h0);
    #1;
    chk32("rst/memAddrFollow", MemAddress, 32'h1001_0040);
    chk1("rst/memReadFollow", MemRead, 1'b1);
    setPipe(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Pipe store preloads memory.
    setPipe(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    midCycle();
    chk1("pre/memWrite", MemWrite, 1'b1);
    chk32("pre/memAddr", MemAddress, 32'h1001_0004);
    chk32("pre/memWData", MemWriteData, 32'hDEAD_BEEF);
    chk1("pre/stall", StallPipe, 1'b0);
    nextCycle();
    setPipe(1'b0, 1'b0, 32'h0, 32'h0);

    // External read with an idle pipe.
    setExt(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'hDEAD_BEEF});
    for (int c = 0; c < 4; c++) begin
      if (c == 3) setExt(1'b0, 1'b0, 32'h0, 32'h0);
      midCycle();
      chk1($sformatf("idle/c%0d/stall", c), StallPipe, 1'b0);
      chk1($sformatf("idle/c%0d/ack", c), ExtAck, c == 2);
      chk1($sformatf("idle/c%0d/memRead", c), MemRead, c == 1);
      if (c == 1) chk32("idle/c1/memAddr", MemAddress, 32'h1001_0004);
      if (c == 2) checkAck("idle");
      if (c == 3) chk32("idle/c3/held", ExtReadData, 32'hDEAD_BEEF);
      nextCycle();
    end

    // Forced grant after MAX_WAIT cycles behind continuous pipe loads.
    setPipe(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    setExt(1'b1, 1'b1, 32'h1001_0010, 32'h0000_CAFE);
    sbQ.push_back('{isWrite: 1'b1, rdata: 32'h0});
    for (int c = 0; c < 6; c++) begin
      midCycle();
      chk1($sformatf("force/c%0d/stall", c), StallPipe, c == 4);
      chk1($sformatf("force/c%0d/ack", c), ExtAck, c == 5);
      if (c == 4) begin
        chk1("force/c4/memWrite", MemWrite, 1'b1);
        chk1("force/c4/memRead", MemRead, 1'b0);
        chk32("force/c4/memAddr", MemAddress, 32'h1001_0010);
        chk32("force/c4/memWData", MemWriteData, 32'h0000_CAFE);
      end else begin
        chk1($sformatf("force/c%0d/memRead", c), MemRead, 1'b1);
        chk32($sformatf("force/c%0d/memAddr", c), MemAddress, 32'h1001_0004);
        chk32($sformatf("force/c%0d/pipeRData", c), PipeReadData, 32'hDEAD_BEEF);
      end
      if (c == 5) checkAck("force");
      nextCycle();
    end
    setExt(1'b0, 1'b0, 32'h0, 32'h0);
    setPipe(1'b1, 1'b0, 32'h1001_0010, 32'h0);
    midCycle();
    chk32("force/readBack", PipeReadData, 32'h0000_CAFE);
    chk1("force/ackDone", ExtAck, 1'b0);
    nextCycle();
    setPipe(1'b0, 1'b0, 32'h0, 32'h0);

    // Simultaneous pipe store and external read: pipe wins, ext follows.
    setPipe(1'b0, 1'b1, 32'h1001_0020, 32'h1111_1111);
    setExt(1'b1, 1'b0, 32'h1001_0020, 32'h0);
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'h1111_1111});
    for (int c = 0; c < 5; c++) begin
      if (c == 1) setPipe(1'b0, 1'b0, 32'h0, 32'h0);
      if (c == 4) setExt(1'b0, 1'b0, 32'h0, 32'h0);
      midCycle();
      chk1($sformatf("tie/c%0d/memWrite", c), MemWrite, c == 0);
      chk1($sformatf("tie/c%0d/memRead", c), MemRead, c == 2);
      chk1($sformatf("tie/c%0d/ack", c), ExtAck, c == 3);
      chk1($sformatf("tie/c%0d/stall", c), StallPipe, 1'b0);
      if (c == 0) chk32("tie/c0/memWData", MemWriteData, 32'h1111_1111);
      if (c == 2) chk32("tie/c2/memAddr", MemAddress, 32'h1001_0020);
      if (c == 3) checkAck("tie");
      nextCycle();
    end

    // Request held through ExtAck becomes a new request, never back-to-back.
    setExt(1'b1, 1'b0, 32'h1001_0010, 32'h0);
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'h0000_CAFE});
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'h0000_CAFE});
    for (int c = 0; c < 8; c++) begin
      if (c == 6) setExt(1'b0, 1'b0, 32'h0, 32'h0);
      midCycle();
      chk1($sformatf("held/c%0d/memRead", c), MemRead, c == 1 || c == 4);
      chk1($sformatf("held/c%0d/ack", c), ExtAck, c == 2 || c == 5);
      if (c == 2 || c == 5) checkAck($sformatf("held/c%0d", c));
      nextCycle();
    end

    // Reset asserted while ExtAck is high clears outputs without a clock.
    setExt(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'hDEAD_BEEF});
    repeat (2) begin
      midCycle();
      nextCycle();
    end
    midCycle();
    chk1("rstAck/ackBefore", ExtAck, 1'b1);
    checkAck("rstAck");
    setPipe(1'b1, 1'b0, 32'h1001_0030, 32'h0);
    #1;
    reset = 1'b0;
    expReadData = 32'h0;
    #1;
    chk1("rstAck/ack", ExtAck, 1'b0);
    chk32("rstAck/extReadData", ExtReadData, expReadData);
    chk32("rstAck/memAddr", MemAddress, 32'h1001_0030);
    chk1("rstAck/memRead", MemRead, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    setPipe(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset during an external write access aborts it: no write, no ack.
    setExt(1'b1, 1'b1, 32'h1001_0004, 32'h5555_5555);
    midCycle();
    nextCycle();
    midCycle();
    chk1("rstAcc/memWriteBefore", MemWrite, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk1("rstAcc/memWrite", MemWrite, 1'b0);
    chk1("rstAcc/ack", ExtAck, 1'b0);
`ifdef DATA_MEM_ARB_STATS_EN
    chk32("stats/rstPipe", 32'(PipeGrantCount), 32'h0);
    chk32("stats/rstExt", 32'(ExtGrantCount), 32'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    setExt(1'b0, 1'b0, 32'h0, 32'h0);

    // Five unstalled pipe loads; the aborted write must not have landed.
    setPipe(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    for (int c = 0; c < 5; c++) begin
      midCycle();
      chk32($sformatf("rstAcc/c%0d/pipeRData", c), PipeReadData, 32'hDEAD_BEEF);
      chk1($sformatf("rstAcc/c%0d/ack", c), ExtAck, 1'b0);
      nextCycle();
    end
    setPipe(1'b0, 1'b0, 32'h0, 32'h0);

    // Two external reads with an idle pipe.
    setExt(1'b1, 1'b0, 32'h1001_0020, 32'h0);
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'h1111_1111});
    sbQ.push_back('{isWrite: 1'b0, rdata: 32'h1111_1111});
    for (int c = 0; c < 7; c++) begin
      if (c == 6) setExt(1'b0, 1'b0, 32'h0, 32'h0);
      midCycle();
      chk1($sformatf("two/c%0d/ack", c), ExtAck, c == 2 || c == 5);
      if (c == 2 || c == 5) checkAck($sformatf("two/c%0d", c));
      nextCycle();
    end
`ifdef DATA_MEM_ARB_STATS_EN
    midCycle();
    chk32("stats/pipe", 32'(PipeGrantCount), 32'd5);
    chk32("stats/ext", 32'(ExtGrantCount), 32'd2);
`endif

    chk32("sb/drained", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
